// File: rtl/gpu_launcher_if.sv
// gpu_launcher_if
// Bundles every signal between the kernel launcher and its two neighbours:
// the host side (launch commands in, completion reports out) and the gpu
// side (reset, device-control write, start, done).
//
// Signals:
//   cmd_valid / cmd_ready / cmd_thread_count       host launch request
//   rsp_valid / rsp_ready / rsp_cycles / rsp_timeout  completion report
//   gpu_reset, device_control_write_enable,
//   device_control_data, start                     launcher -> gpu controls
//   done                                           gpu -> launcher
//   busy                                           launcher activity flag
//
// Modports:
//   slave  - the launcher itself
//   master - the host/gpu environment that drives the launcher
interface gpu_launcher_if #(
    parameter int CYCLE_BITS = 16
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [7:0]            cmd_thread_count;
    logic                  gpu_reset;
    logic                  device_control_write_enable;
    logic [7:0]            device_control_data;
    logic                  start;
    logic                  done;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [CYCLE_BITS-1:0] rsp_cycles;
    logic                  rsp_timeout;
    logic                  busy;

    modport slave (
        input  cmd_valid, cmd_thread_count, done, rsp_ready,
        output cmd_ready, gpu_reset, device_control_write_enable,
               device_control_data, start, rsp_valid, rsp_cycles,
               rsp_timeout, busy
    );

    modport master (
        output cmd_valid, cmd_thread_count, done, rsp_ready,
        input  cmd_ready, gpu_reset, device_control_write_enable,
               device_control_data, start, rsp_valid, rsp_cycles,
               rsp_timeout, busy
    );
endinterface

// File: rtl/gpu_launcher.sv
// gpu_launcher
// Queues kernel launch commands from a host and sequences each one onto the
// gpu: one cycle of gpu reset, one device-control write of the thread count,
// then start held until the gpu reports done or the run times out. Each
// kernel produces one completion report (cycles used, timeout flag).
//
// Ports:
//   clk    - single clock, rising edge
//   reset  - asynchronous, active-low
//   bus    - gpu_launcher_if.slave carrying the command, report and gpu
//            control signals
module gpu_launcher #(
    parameter int                    QUEUE_DEPTH    = 4,
    parameter int                    CYCLE_BITS     = 16,
    parameter logic [CYCLE_BITS-1:0] TIMEOUT_CYCLES = 16'hFFFF
) (
    input  logic           clk,
    input  logic           reset,
    gpu_launcher_if.slave  bus
);
    localparam int                    PTR_W    = $clog2(QUEUE_DEPTH);
    localparam logic [PTR_W-1:0]      PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0]        CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0]        CNT_FULL = (PTR_W+1)'(QUEUE_DEPTH);
    localparam logic [CYCLE_BITS-1:0] CYC_ONE  = {{(CYCLE_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        GPU_RST,
        DCR_WR,
        RUN,
        ABORT,
        RESP
    } state_t;

    state_t                state;
    state_t                next_state;

    logic [7:0]            fifo_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        fifo_count;
    logic [7:0]            head;
    logic                  push;
    logic                  pop;

    logic [7:0]            thread_count;
    logic [CYCLE_BITS-1:0] counter;
    logic [CYCLE_BITS-1:0] counter_inc;
    logic [CYCLE_BITS-1:0] rsp_cycles_q;
    logic                  rsp_timeout_q;
    logic                  gpu_reset_q;
    logic                  dcr_we_q;
    logic [7:0]            dcr_data_q;
    logic                  start_q;
    logic                  rsp_valid_q;

    assign head        = fifo_mem[rd_ptr];
    assign push        = bus.cmd_valid && bus.cmd_ready;
    // The counter value seen "in" the current RUN cycle, so the first RUN
    // cycle reads 1; it sticks at all-ones instead of wrapping.
    assign counter_inc = (counter == '1) ? counter : counter + CYC_ONE;

    // Command storage. Entries need no reset: only occupancy decides what
    // is valid, and occupancy is cleared by reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.cmd_thread_count;
        end
    end

    // FIFO pointers and occupancy. A simultaneous push and pop leaves the
    // occupancy unchanged; pointers wrap naturally since the depth is a
    // power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_ONE;
                2'b01:   fifo_count <= fifo_count - CNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. The FIFO is popped only from IDLE, which guarantees
    // at least one IDLE cycle between a report handshake and the next pop.
    // done is looked at only in RUN, and it beats the timeout when both
    // happen in the same cycle.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop        = 1'b1;
                    next_state = (head == 8'd0) ? RESP : GPU_RST;
                end
            end
            GPU_RST: next_state = DCR_WR;
            DCR_WR:  next_state = RUN;
            RUN: begin
                if (bus.done) begin
                    next_state = RESP;
                end else if ((TIMEOUT_CYCLES != '0) && (counter_inc == TIMEOUT_CYCLES)) begin
                    next_state = ABORT;
                end
            end
            ABORT:   next_state = RESP;
            RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: latched thread count, run counter and report fields. The
    // report fields change only on the way into RESP, so they stay stable
    // while the host applies backpressure.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            thread_count  <= '0;
            counter       <= '0;
            rsp_cycles_q  <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            if (pop) begin
                thread_count <= head;
            end
            case (state)
                IDLE: begin
                    if (pop && (head == 8'd0)) begin
                        rsp_cycles_q  <= '0;
                        rsp_timeout_q <= 1'b0;
                    end
                end
                DCR_WR: counter <= '0;
                RUN: begin
                    counter <= counter_inc;
                    if (bus.done) begin
                        rsp_cycles_q  <= counter_inc;
                        rsp_timeout_q <= 1'b0;
                    end
                end
                ABORT: begin
                    rsp_cycles_q  <= TIMEOUT_CYCLES;
                    rsp_timeout_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // GPU controls and report valid are registered copies of the state
    // being entered, so they are glitch-free, mutually exclusive by
    // construction, and drop the instant reset is asserted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpu_reset_q <= 1'b0;
            dcr_we_q    <= 1'b0;
            dcr_data_q  <= '0;
            start_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            gpu_reset_q <= (next_state == GPU_RST) || (next_state == ABORT);
            dcr_we_q    <= (next_state == DCR_WR);
            dcr_data_q  <= (next_state == DCR_WR) ? thread_count : 8'd0;
            start_q     <= (next_state == RUN);
            rsp_valid_q <= (next_state == RESP);
        end
    end

    assign bus.cmd_ready                   = (fifo_count != CNT_FULL);
    assign bus.gpu_reset                   = gpu_reset_q;
    assign bus.device_control_write_enable = dcr_we_q;
    assign bus.device_control_data         = dcr_data_q;
    assign bus.start                       = start_q;
    assign bus.rsp_valid                   = rsp_valid_q;
    assign bus.rsp_cycles                  = rsp_cycles_q;
    assign bus.rsp_timeout                 = rsp_timeout_q;
    assign bus.busy                        = (state != IDLE) || (fifo_count != '0);
endmodule
